// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: default window base,
// register indices (Address[4:2]) and CTRL/STATUS bit positions.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'hFFFF_0000;

  typedef enum logic [2:0] {
    REG_PORT_OUT = 3'd0,
    REG_PORT_IN  = 3'd1,
    REG_EDGE     = 3'd2,
    REG_CTRL     = 3'd3,
    REG_LOAD     = 3'd4,
    REG_COUNT    = 3'd5,
    REG_STATUS   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_idx_e;

  localparam int CTRL_EN            = 0;
  localparam int CTRL_AUTO_RELOAD   = 1;
  localparam int CTRL_IRQ_MASK_TMR  = 2;
  localparam int CTRL_IRQ_MASK_EDGE = 3;

  localparam int STATUS_EXPIRED  = 0;
  localparam int STATUS_EDGE_ANY = 1;

endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory bus as seen by an MMIO target (processor side is the master).
interface mmio_port_responder_if;
  // No valid/ready: MemWrite commits at the rising edge when Hit; MemRead
  // qualifies ReadData combinationally in the same cycle; a target never stalls.
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (output Address, WriteData, MemWrite, MemRead,
                  input  ReadData, Hit);
  modport slave  (input  Address, WriteData, MemWrite, MemRead,
                  output ReadData, Hit);
endinterface

// File: rtl/mmio_input_sync.sv
// Synchronizer chain for an asynchronous input bus plus a previous-value
// register; emits the synced value and a per-bit change pulse.
module mmio_input_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out,
  output logic [W-1:0] change
);

  logic [W-1:0] chain_q [STAGES];
  logic [W-1:0] chain_d [STAGES];
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  always_comb begin
    chain_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) chain_d[i] = chain_q[i-1];
    prev_d = chain_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= chain_d[i];
      prev_q <= prev_d;
    end
  end

  assign sync_out = chain_q[STAGES-1];
  assign change   = sync_out ^ prev_q;

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: PortOut latch, synced PortIn with sticky edge flags and a
// down-counting timer. Define MMIO_IRQ_EN to add the IRQ output and CTRL mask bits.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MMIO_BASE_ADDR,
  parameter int          IN_WIDTH    = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut
`ifdef MMIO_IRQ_EN
  ,
  output logic                IRQ
`endif
);

`ifdef MMIO_IRQ_EN
  localparam int CTRL_W = 4;
`else
  localparam int CTRL_W = 2;
`endif

  logic                hit;
  logic                wr_en;
  reg_idx_e            idx;
  logic [IN_WIDTH-1:0] sync_in;
  logic [IN_WIDTH-1:0] change;
  logic                expire;
  logic [31:0]         rdata;
  logic                unused_addr;

  logic [31:0]         port_out_q, port_out_d;
  logic [IN_WIDTH-1:0] edge_q,     edge_d;
  logic [CTRL_W-1:0]   ctrl_q,     ctrl_d;
  logic [31:0]         load_q,     load_d;
  logic [31:0]         count_q,    count_d;
  logic                expired_q,  expired_d;
`ifdef MMIO_IRQ_EN
  logic                irq_q,      irq_d;
`endif

  mmio_input_sync #(.W(IN_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (PortIn),
    .sync_out (sync_in),
    .change   (change)
  );

  assign hit         = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign idx         = reg_idx_e'(bus.Address[4:2]);
  assign wr_en       = bus.MemWrite && hit;
  assign unused_addr = ^bus.Address[1:0];

  always_comb begin
    port_out_d = port_out_q;
    edge_d     = edge_q;
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    expired_d  = expired_q;
    expire     = 1'b0;

    if (ctrl_q[CTRL_EN]) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        expire = 1'b1;
        if (ctrl_q[CTRL_AUTO_RELOAD]) count_d = load_q;
        else                          ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    if (wr_en) begin
      case (idx)
        REG_PORT_OUT: port_out_d = bus.WriteData;
        REG_EDGE:     edge_d     = edge_q & ~bus.WriteData[IN_WIDTH-1:0];
        REG_CTRL:     ctrl_d     = bus.WriteData[CTRL_W-1:0];
        REG_LOAD: begin
          load_d  = bus.WriteData;
          count_d = bus.WriteData;
        end
        REG_STATUS:   if (bus.WriteData[STATUS_EXPIRED]) expired_d = 1'b0;
        default: ;
      endcase
    end

    // Hardware sets are applied last so they win over a same-cycle W1C.
    edge_d = edge_d | change;
    if (expire) expired_d = 1'b1;
  end

`ifdef MMIO_IRQ_EN
  assign irq_d = (expired_q & ctrl_q[CTRL_IRQ_MASK_TMR]) |
                 ((|edge_q) & ctrl_q[CTRL_IRQ_MASK_EDGE]);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= '0;
      edge_q     <= '0;
      ctrl_q     <= '0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
`ifdef MMIO_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      port_out_q <= port_out_d;
      edge_q     <= edge_d;
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
`ifdef MMIO_IRQ_EN
      irq_q      <= irq_d;
`endif
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (bus.MemRead && hit) begin
      case (idx)
        REG_PORT_OUT: rdata = port_out_q;
        REG_PORT_IN:  rdata = 32'(sync_in);
        REG_EDGE:     rdata = 32'(edge_q);
        REG_CTRL:     rdata = 32'(ctrl_q);
        REG_LOAD:     rdata = load_q;
        REG_COUNT:    rdata = count_q;
        REG_STATUS:   rdata = 32'({|edge_q, expired_q});
        default:      rdata = 32'h0;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign bus.Hit      = hit;
  assign PortOut      = port_out_q;
`ifdef MMIO_IRQ_EN
  assign IRQ          = irq_q;
`endif

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder; covers the IRQ path when MMIO_IRQ_EN is defined.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [4:0] O_PORT_OUT = 5'h00, O_PORT_IN = 5'h04, O_EDGE = 5'h08,
                         O_CTRL = 5'h0C, O_LOAD = 5'h10, O_COUNT = 5'h14,
                         O_STATUS = 5'h18, O_RSVD = 5'h1C;
`ifdef MMIO_IRQ_EN
  localparam logic [31:0] CTRL_ALL = 32'h0000_000F;
`else
  localparam logic [31:0] CTRL_ALL = 32'h0000_0003;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  port_in;
  logic [31:0] port_out;
`ifdef MMIO_IRQ_EN
  logic        irq;
`endif

  int n_assert;
  int n_fail;

  mmio_port_responder_if bus ();

  mmio_port_responder dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PortIn  (port_in),
    .PortOut (port_out)
`ifdef MMIO_IRQ_EN
    ,
    .IRQ     (irq)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Write: drive at a negedge, commits at the following posedge, returns at next negedge.
  task automatic wr_addr(input logic [31:0] addr, input logic [31:0] data);
    bus.Address   = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] data);
    wr_addr(BASE + 32'(off), data);
  endtask

  task automatic rd_addr(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus.Address = addr;
    bus.MemRead = 1'b1;
    #1;
    chk(tag, bus.ReadData, exp);
    bus.MemRead = 1'b0;
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string tag);
    rd_addr(BASE + 32'(off), exp, tag);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    port_in       = 8'h00;
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);

    // Reset state
    chk("rst_portout", port_out, 32'h0);
    rd(O_PORT_OUT, 32'h0, "rst_port_out_reg");
    rd(O_COUNT,    32'h0, "rst_count");
    rd(O_STATUS,   32'h0, "rst_status");
    rd(O_EDGE,     32'h0, "rst_edge");
    rd(O_CTRL,     32'h0, "rst_ctrl");

    // Reset asserted mid-count
    wr(O_PORT_OUT, 32'h1234_5678);
    wr(O_LOAD, 32'd10);
    wr(O_CTRL, 32'h1);
    step(5);
    rd(O_COUNT, 32'd5, "midcount_before_rst");
    #2 reset = 1'b0;
    #1 chk("async_rst_portout", port_out, 32'h0);
    rd(O_COUNT, 32'h0, "async_rst_count");
    @(negedge clk);
    reset = 1'b1;
    step(3);
    rd(O_COUNT, 32'h0, "post_rst_count");
    rd(O_LOAD,  32'h0, "post_rst_load");
    rd(O_CTRL,  32'h0, "post_rst_ctrl");

    // PortOut and decode
    wr(O_PORT_OUT, 32'hDEAD_BEEF);
    chk("portout_dead", port_out, 32'hDEAD_BEEF);
    rd(O_PORT_OUT, 32'hDEAD_BEEF, "rd_port_out");
    bus.Address = BASE + 32'h40;
    #1 chk("miss_hit", 32'(bus.Hit), 32'h0);
    rd_addr(BASE + 32'h40, 32'h0, "miss_rdata");
    wr_addr(BASE + 32'h40, 32'h1111_2222);
    chk("miss_write_ignored", port_out, 32'hDEAD_BEEF);
    bus.Address = BASE + 32'h1F;
    #1 chk("hit_top_byte", 32'(bus.Hit), 32'h1);
    rd_addr(BASE + 32'h03, 32'hDEAD_BEEF, "low_addr_bits_ignored");
    wr(O_RSVD, 32'hFFFF_FFFF);
    rd(O_RSVD, 32'h0, "reserved_reads_0");
    chk("reserved_write_ignored", port_out, 32'hDEAD_BEEF);

    // PortIn sync and edge flags
    port_in = 8'hA5;
    step(1);
    rd(O_PORT_IN, 32'h0, "portin_after_1_edge");
    step(1);
    rd(O_PORT_IN, 32'hA5, "portin_after_2_edges");
    rd(O_EDGE,    32'h0,  "edge_not_yet");
    step(1);
    rd(O_EDGE,    32'hA5, "edge_set");
    rd(O_STATUS,  32'h2,  "status_edge_any");
    wr(O_EDGE, 32'h05);
    rd(O_EDGE, 32'hA0, "edge_w1c");
    port_in = 8'hA4;
    step(2);
    wr(O_EDGE, 32'h01);
    rd(O_EDGE, 32'hA1, "edge_set_beats_clear");
    wr(O_EDGE, 32'hFF);
    rd(O_EDGE, 32'h0, "edge_clear_all");
    rd(O_STATUS, 32'h0, "status_after_edge_clear");

    // One-shot timer
    wr(O_LOAD, 32'd3);
    wr(O_CTRL, 32'h1);
    rd(O_COUNT, 32'd3, "oneshot_c3");
    step(1); rd(O_COUNT, 32'd2, "oneshot_c2");
    step(1); rd(O_COUNT, 32'd1, "oneshot_c1");
    step(1); rd(O_COUNT, 32'd0, "oneshot_c0");
    rd(O_STATUS, 32'h0, "oneshot_not_expired_yet");
    step(1);
    rd(O_STATUS, 32'h1, "oneshot_expired");
    rd(O_CTRL,   32'h0, "oneshot_en_cleared");
    step(1);
    rd(O_COUNT,  32'd0, "oneshot_holds_0");
    wr(O_STATUS, 32'h1);
    rd(O_STATUS, 32'h0, "expired_w1c");

    // Auto-reload timer
    wr(O_LOAD, 32'd3);
    wr(O_CTRL, 32'h3);
    step(1); rd(O_COUNT, 32'd2, "reload_c2");
    step(1); rd(O_COUNT, 32'd1, "reload_c1");
    step(1); rd(O_COUNT, 32'd0, "reload_c0");
    step(1); rd(O_COUNT, 32'd3, "reload_c3");
    rd(O_STATUS, 32'h1, "reload_expired");
    rd(O_CTRL,   32'h3, "reload_en_kept");
    step(4); rd(O_COUNT, 32'd3, "reload_second_wrap");
    wr(O_CTRL, 32'h0);
    rd(O_COUNT, 32'd2, "disable_last_decrement");
    step(2);
    rd(O_COUNT, 32'd2, "disabled_holds");
    wr(O_STATUS, 32'h1);

    // Read and write LOAD in the same cycle
    wr(O_LOAD, 32'd7);
    bus.Address   = BASE + 32'(O_LOAD);
    bus.WriteData = 32'd9;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    #1 chk("rmw_old_value", bus.ReadData, 32'd7);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    rd(O_LOAD,  32'd9, "rmw_load_new");
    rd(O_COUNT, 32'd9, "rmw_count_new");

    // CTRL readback of implemented bits
    wr(O_CTRL, 32'hFFFF_FFFC);
    rd(O_CTRL, CTRL_ALL & 32'hC, "ctrl_upper_bits");
    wr(O_CTRL, 32'h0);

`ifdef MMIO_IRQ_EN
    chk("irq_idle", 32'(irq), 32'h0);
    wr(O_LOAD, 32'd1);
    wr(O_CTRL, 32'h5);
    step(1);
    rd(O_COUNT, 32'd0, "irq_count0");
    step(1);
    rd(O_STATUS, 32'h1, "irq_expired");
    chk("irq_not_yet", 32'(irq), 32'h0);
    step(1);
    chk("irq_asserted", 32'(irq), 32'h1);
    wr(O_STATUS, 32'h1);
    chk("irq_lag_after_clear", 32'(irq), 32'h1);
    step(1);
    chk("irq_cleared", 32'(irq), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
